// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a prefetch FIFO and branch redirect.
// Requests words from instruction memory, tags each response with its PC through a
// PC queue written at grant time, and hands {inst, pc} to decode over valid/ready.
// A redirect flushes the FIFO and drops in-flight responses before refetching.
// Optional feature macro: FETCH_STATS_EN adds stat_fetched / stat_flushed counters.

module fetch_unit #(
   parameter int unsigned       WIDTH    = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [WIDTH-1:0]  RESET_PC = '0,
   parameter logic [WIDTH-1:0]  PC_INC   = 1
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [WIDTH-1:0] imem_rdata,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_addr,
   output logic             inst_valid,
   output logic [WIDTH-1:0] inst,
   output logic [WIDTH-1:0] inst_pc,
`ifdef FETCH_STATS_EN
   output logic [31:0]      stat_fetched,
   output logic [31:0]      stat_flushed,
`endif
   input  logic             inst_ready
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
   localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(DEPTH);

   typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]     outstanding_q, outstanding_d;
   logic [CW-1:0]     discard_q, discard_d;
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     pcq_rd_q, pcq_rd_d;
   logic [PW-1:0]     pcq_wr_q, pcq_wr_d;
   logic [WIDTH-1:0]  fifo_inst_q [DEPTH];
   logic [WIDTH-1:0]  fifo_inst_d [DEPTH];
   logic [WIDTH-1:0]  fifo_pc_q   [DEPTH];
   logic [WIDTH-1:0]  fifo_pc_d   [DEPTH];
   logic [WIDTH-1:0]  pcq_q       [DEPTH];
   logic [WIDTH-1:0]  pcq_d       [DEPTH];
   logic              imem_req_q, imem_req_d;
   logic              inst_valid_q, inst_valid_d;
   logic [WIDTH-1:0]  inst_q, inst_d;
   logic [WIDTH-1:0]  inst_pc_q, inst_pc_d;
   logic              gnt_fire, deq_fire, fifo_wr;
   logic [CW:0]       occ_d;

   assign gnt_fire = imem_req_q & imem_gnt;
   assign deq_fire = inst_valid_q & inst_ready;

   // Next-state: PC queue, outstanding tracking, FSM, FIFO and registered outputs
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      discard_d     = discard_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      pcq_rd_d      = pcq_rd_q;
      pcq_wr_d      = pcq_wr_q;
      fifo_inst_d   = fifo_inst_q;
      fifo_pc_d     = fifo_pc_q;
      pcq_d         = pcq_q;
      fifo_wr       = 1'b0;

      // The PC queue follows every granted request until its response returns,
      // whether that response is kept or dropped, so it is never flushed.
      if (gnt_fire) begin
         pcq_d[pcq_wr_q] = fetch_pc_q;
         pcq_wr_d        = pcq_wr_q + PW'(1);
      end
      if (imem_rvalid) begin
         pcq_rd_d = pcq_rd_q + PW'(1);
      end
      outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(imem_rvalid);

      if (redirect) begin
         // Everything in flight after this cycle (including a same-cycle grant) is dropped
         fetch_pc_d = redirect_addr;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         discard_d  = outstanding_d;
         state_d    = (outstanding_d != '0) ? FLUSH : RUN;
      end else begin
         if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + PC_INC;
         end
         case (state_q)
            BOOT:  state_d = RUN;
            RUN:   fifo_wr = imem_rvalid;
            FLUSH: begin
               if (imem_rvalid) begin
                  discard_d = discard_q - CW'(1);
                  if (discard_d == '0) begin
                     state_d = RUN;
                  end
               end
            end
            default: state_d = BOOT;
         endcase
         if (fifo_wr) begin
            fifo_inst_d[wr_ptr_q] = imem_rdata;
            fifo_pc_d[wr_ptr_q]   = pcq_q[pcq_rd_q];
            wr_ptr_d              = wr_ptr_q + PW'(1);
         end
         if (deq_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(fifo_wr) - CW'(deq_fire);
      end

      occ_d        = {1'b0, count_d} + {1'b0, outstanding_d};
      imem_req_d   = (state_d == RUN) && (occ_d < DEPTH_OCC);
      inst_valid_d = (count_d != '0);
      inst_d       = inst_valid_d ? fifo_inst_d[rd_ptr_d] : '0;
      inst_pc_d    = inst_valid_d ? fifo_pc_d[rd_ptr_d]   : '0;
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= BOOT;
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         pcq_rd_q      <= '0;
         pcq_wr_q      <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_inst_q[i] <= '0;
            fifo_pc_q[i]   <= '0;
            pcq_q[i]       <= '0;
         end
         imem_req_q    <= 1'b0;
         inst_valid_q  <= 1'b0;
         inst_q        <= '0;
         inst_pc_q     <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         pcq_rd_q      <= pcq_rd_d;
         pcq_wr_q      <= pcq_wr_d;
         fifo_inst_q   <= fifo_inst_d;
         fifo_pc_q     <= fifo_pc_d;
         pcq_q         <= pcq_d;
         imem_req_q    <= imem_req_d;
         inst_valid_q  <= inst_valid_d;
         inst_q        <= inst_d;
         inst_pc_q     <= inst_pc_d;
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = fetch_pc_q;
   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;

   // Request throttling keeps count+outstanding <= DEPTH, so a full-FIFO write is a bug
   fifo_overflow_a : assert property (@(posedge clk) disable iff (!reset)
      !(fifo_wr && (count_q == DEPTH_CNT)));

`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched_q, stat_fetched_d;
   logic [31:0] stat_flushed_q, stat_flushed_d;
   logic [32:0] flushed_sum;

   // Saturating counters; in FLUSH the in-flight words were already counted at the earlier redirect
   always_comb begin
      stat_fetched_d = stat_fetched_q;
      stat_flushed_d = stat_flushed_q;
      flushed_sum    = {1'b0, stat_flushed_q} + 33'(count_q);
      if (state_q != FLUSH) begin
         flushed_sum = flushed_sum + 33'(outstanding_q) + 33'(gnt_fire);
      end
      if (redirect) begin
         stat_flushed_d = flushed_sum[32] ? '1 : flushed_sum[31:0];
      end else if (deq_fire && (stat_fetched_q != '1)) begin
         stat_fetched_d = stat_fetched_q + 32'd1;
      end
   end

   // Statistics registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_fetched_q <= '0;
         stat_flushed_q <= '0;
      end else begin
         stat_fetched_q <= stat_fetched_d;
         stat_flushed_q <= stat_flushed_d;
      end
   end

   assign stat_fetched = stat_fetched_q;
   assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for fetch_unit with an in-order memory model
// whose response word is address + 0x1000_0000.

module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_addr = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;
`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched;
   logic [31:0] stat_flushed;
`endif

   int total = 0;
   int bad   = 0;

   // memory model state
   int          lat    = 1;
   logic        mem_en = 1'b0;
   int          cyc    = 0;
   int          q_due  [$];
   logic [31:0] q_addr [$];

   localparam logic [31:0] DOFS = 32'h1000_0000;

   fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0), .PC_INC(32'h1)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .inst_valid    (inst_valid),
      .inst          (inst),
      .inst_pc       (inst_pc),
`ifdef FETCH_STATS_EN
      .stat_fetched  (stat_fetched),
      .stat_flushed  (stat_flushed),
`endif
      .inst_ready    (inst_ready)
   );

   always #5 clk = ~clk;

   // In-order memory: grants seen in cycle c answer in cycle c+lat
   always @(posedge clk) begin
      #2;
      cyc++;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (!mem_en) begin
         q_due.delete();
         q_addr.delete();
      end else begin
         if (q_due.size() > 0 && q_due[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = q_addr[0] + DOFS;
            void'(q_due.pop_front());
            void'(q_addr.pop_front());
         end
         if (imem_req && imem_gnt) begin
            q_due.push_back(cyc + lat);
            q_addr.push_back(imem_addr);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      mem_en   = 1'b0;
      redirect = 1'b0;
      imem_gnt = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b1;
      mem_en = 1'b1;
   endtask

   task automatic test_reset();
      lat = 1;
      reset = 1'b0; imem_gnt = 1'b0; inst_ready = 1'b0; mem_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem_req); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", inst_valid); end
      total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h want=0", inst); end
      total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", inst_pc); end
`ifdef FETCH_STATS_EN
      total++; if (stat_fetched !== 32'h0) begin bad++; $display("FAIL reset_stat_fetched got=%h want=0", stat_fetched); end
`endif
      reset = 1'b1; mem_en = 1'b1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_req got=%b want=0", imem_req); end
      tick();
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL run_req got=%b want=1", imem_req); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL run_addr got=%h want=0", imem_addr); end
   endtask

   task automatic test_stream();
      logic [31:0] exp_addr, exp_pc;
      int n_valid;
      lat = 1; do_reset(); imem_gnt = 1'b1; inst_ready = 1'b1;
      exp_addr = 0; exp_pc = 0; n_valid = 0;
      for (int i = 0; i < 21; i++) begin
         if (imem_req && imem_gnt) begin
            total++; if (imem_addr !== exp_addr) begin bad++; $display("FAIL stream_addr got=%h want=%h", imem_addr, exp_addr); end
            exp_addr++;
         end
         if (inst_valid) begin
            n_valid++;
            total++; if (inst_pc !== exp_pc) begin bad++; $display("FAIL stream_pc got=%h want=%h", inst_pc, exp_pc); end
            total++; if (inst !== exp_pc + DOFS) begin bad++; $display("FAIL stream_inst got=%h want=%h", inst, exp_pc + DOFS); end
            exp_pc++;
         end
         tick();
      end
      total++; if (n_valid !== 18) begin bad++; $display("FAIL stream_rate got=%0d want=18", n_valid); end
      total++; if (exp_addr !== 32'd20) begin bad++; $display("FAIL stream_grants got=%0d want=20", exp_addr); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_addr, exp_pc;
      int n_gnt;
      lat = 1; do_reset(); imem_gnt = 1'b1; inst_ready = 1'b0;
      exp_addr = 0; n_gnt = 0;
      for (int i = 0; i < 13; i++) begin
         if (imem_req && imem_gnt) begin
            total++; if (imem_addr !== exp_addr) begin bad++; $display("FAIL bp_addr got=%h want=%h", imem_addr, exp_addr); end
            exp_addr++; n_gnt++;
         end
         tick();
      end
      total++; if (n_gnt !== 4) begin bad++; $display("FAIL bp_grants got=%0d want=4", n_gnt); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_off got=%b want=0", imem_req); end
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", inst_valid); end
      total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL bp_head_pc got=%h want=0", inst_pc); end
      inst_ready = 1'b1; exp_pc = 0;
      for (int i = 0; i < 16; i++) begin
         if (imem_req && imem_gnt) begin
            total++; if (imem_addr !== exp_addr) begin bad++; $display("FAIL bp_resume_addr got=%h want=%h", imem_addr, exp_addr); end
            exp_addr++;
         end
         if (inst_valid && inst_ready) begin
            total++; if (inst_pc !== exp_pc) begin bad++; $display("FAIL bp_pc got=%h want=%h", inst_pc, exp_pc); end
            exp_pc++;
         end
         tick();
      end
      total++; if (exp_pc !== 32'd16) begin bad++; $display("FAIL bp_drained got=%0d want=16", exp_pc); end
   endtask

   task automatic test_gnt_stall();
      logic [31:0] exp_pc;
      int   stall_left;
      logic stalled_once, granted2;
      lat = 1; do_reset(); imem_gnt = 1'b1; inst_ready = 1'b1;
      exp_pc = 0; stall_left = 0; stalled_once = 1'b0; granted2 = 1'b0;
      for (int i = 0; i < 60 && exp_pc < 8; i++) begin
         if (inst_valid) begin
            total++; if (inst_pc !== exp_pc) begin bad++; $display("FAIL stall_pc got=%h want=%h", inst_pc, exp_pc); end
            if (inst_pc == 32'd2) begin
               total++; if (granted2 !== 1'b1) begin bad++; $display("FAIL stall_early got=%b want=1", granted2); end
            end
            exp_pc++;
         end
         if (stall_left > 0) begin
            total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stall_req got=%b want=1", imem_req); end
            total++; if (imem_addr !== 32'd2) begin bad++; $display("FAIL stall_addr got=%h want=2", imem_addr); end
            stall_left--;
            imem_gnt = (stall_left == 0);
         end else if (!stalled_once && imem_req && imem_addr == 32'd2) begin
            stalled_once = 1'b1; stall_left = 5; imem_gnt = 1'b0;
         end else begin
            imem_gnt = 1'b1;
         end
         if (imem_req && imem_gnt && imem_addr == 32'd2) granted2 = 1'b1;
         tick();
      end
      total++; if (exp_pc !== 32'd8) begin bad++; $display("FAIL stall_progress got=%0d want=8", exp_pc); end
   endtask

   task automatic test_redirect_flush();
      logic seen_gnt, got;
      lat = 3; do_reset(); inst_ready = 1'b0; imem_gnt = 1'b0;
      tick(); imem_gnt = 1'b1;   // C1: grant addr 0
      tick(); imem_gnt = 1'b0;   // C2
      tick(); imem_gnt = 1'b1;   // C3: grant addr 1
      tick(); imem_gnt = 1'b1;   // C4: grant addr 2, response for 0
      tick();                    // C5: 1 entry, 2 in flight
      total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin bad++; $display("FAIL rf_pre got=%b/%h want=1/0", inst_valid, inst_pc); end
      imem_gnt = 1'b0; redirect = 1'b1; redirect_addr = 32'h100;
      tick(); redirect = 1'b0;   // C6
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rf_valid got=%b want=0", inst_valid); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rf_req_c6 got=%b want=0", imem_req); end
`ifdef FETCH_STATS_EN
      total++; if (stat_flushed !== 32'd3) begin bad++; $display("FAIL rf_stat_flushed got=%0d want=3", stat_flushed); end
`endif
      tick();                    // C7
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rf_req_c7 got=%b want=0", imem_req); end
      imem_gnt = 1'b1; inst_ready = 1'b1; seen_gnt = 1'b0; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (inst_valid) begin
            got = 1'b1;
            total++; if (inst_pc !== 32'h100) begin bad++; $display("FAIL rf_first_pc got=%h want=100", inst_pc); end
            total++; if (inst !== 32'h1000_0100) begin bad++; $display("FAIL rf_first_inst got=%h want=10000100", inst); end
         end
         if (imem_req && imem_gnt && !seen_gnt) begin
            seen_gnt = 1'b1;
            total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL rf_first_addr got=%h want=100", imem_addr); end
         end
         if (!got) tick();
      end
      total++; if (got !== 1'b1) begin bad++; $display("FAIL rf_timeout got=%b want=1", got); end
   endtask

   task automatic test_redirect_same_cycle();
      logic [31:0] exp_pc;
      int n_deq, n_after;
      lat = 1; do_reset(); imem_gnt = 1'b1; inst_ready = 1'b1; n_deq = 0;
      for (int i = 0; i < 6; i++) begin
         if (inst_valid && inst_ready) n_deq++;
         tick();
      end
      total++; if (n_deq !== 3) begin bad++; $display("FAIL sc_pre_deq got=%0d want=3", n_deq); end
      total++; if (inst_valid !== 1'b1 || inst_pc !== 32'd3) begin bad++; $display("FAIL sc_pre_head got=%b/%h want=1/3", inst_valid, inst_pc); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'd5) begin bad++; $display("FAIL sc_pre_req got=%b/%h want=1/5", imem_req, imem_addr); end
      redirect = 1'b1; redirect_addr = 32'h200;
      tick(); redirect = 1'b0;
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL sc_valid got=%b want=0", inst_valid); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL sc_req got=%b want=0", imem_req); end
`ifdef FETCH_STATS_EN
      total++; if (stat_fetched !== 32'd3) begin bad++; $display("FAIL sc_stat_fetched got=%0d want=3", stat_fetched); end
`endif
      exp_pc = 32'h200; n_after = 0;
      for (int i = 0; i < 12; i++) begin
         if (inst_valid && inst_ready) begin
            total++; if (inst_pc !== exp_pc) begin bad++; $display("FAIL sc_pc got=%h want=%h", inst_pc, exp_pc); end
            total++; if (inst !== exp_pc + DOFS) begin bad++; $display("FAIL sc_inst got=%h want=%h", inst, exp_pc + DOFS); end
            exp_pc++; n_after++;
         end
         tick();
      end
      total++; if (n_after !== 9) begin bad++; $display("FAIL sc_count got=%0d want=9", n_after); end
   endtask

   task automatic test_reset_mid_flush();
      logic got;
      lat = 3; do_reset(); imem_gnt = 1'b1; inst_ready = 1'b1;
      tick();                    // C1: grant addr 0
      tick();                    // C2: grant addr 1 with redirect
      redirect = 1'b1; redirect_addr = 32'h300;
      tick(); redirect = 1'b0;   // C3: FLUSH with 2 outstanding
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rm_flush_req got=%b want=0", imem_req); end
      #2;
      mem_en = 1'b0; reset = 1'b0;
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%b want=0", imem_req); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rm_addr got=%h want=0", imem_addr); end
      total++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin bad++; $display("FAIL rm_inst got=%b/%h/%h want=0/0/0", inst_valid, inst, inst_pc); end
`ifdef FETCH_STATS_EN
      total++; if (stat_flushed !== 32'h0) begin bad++; $display("FAIL rm_stat got=%0d want=0", stat_flushed); end
`endif
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1; mem_en = 1'b1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rm_boot got=%b want=0", imem_req); end
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rm_restart got=%b/%h want=1/0", imem_req, imem_addr); end
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         if (inst_valid) begin
            got = 1'b1;
            total++; if (inst_pc !== 32'h0 || inst !== DOFS) begin bad++; $display("FAIL rm_first got=%h/%h want=0/%h", inst_pc, inst, DOFS); end
         end else begin
            tick();
         end
      end
      total++; if (got !== 1'b1) begin bad++; $display("FAIL rm_timeout got=%b want=1", got); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_gnt_stall();
      test_redirect_flush();
      test_redirect_same_cycle();
      test_reset_mid_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of decode/execute in the cpu core.
- Issues sequential word fetches to instruction memory over a request/grant/response interface.
- Buffers returned instructions with their PC in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch redirects from the execute stage: flushes buffered and in-flight fetches, then restarts fetching at the target.

Parameters:
- WIDTH, 32, instruction and address width.
- DEPTH, 4, prefetch FIFO entries (power of two, >= 2); also caps outstanding requests.
- RESET_PC, 0, first fetch address after reset.
- PC_INC, 1, address increment per sequential fetch (word-addressed memory).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- imem_req  out  1  fetch request valid.
- imem_addr  out  WIDTH  fetch address; meaningful only while imem_req=1.
- imem_gnt  in  1  memory accepts the request this cycle when imem_req & imem_gnt.
- imem_rvalid  in  1  response valid; responses return in request order, latency >= 1 cycle.
- imem_rdata  in  WIDTH  response instruction word.
- redirect  in  1  taken branch; flush and refetch.
- redirect_addr  in  WIDTH  branch target.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst  out  WIDTH  FIFO head instruction.
- inst_pc  out  WIDTH  address the head instruction was fetched from.
- inst_ready  in  1  decode consumes the head when inst_valid & inst_ready.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; state=BOOT.
  - Outputs: imem_req=0, inst_valid=0, inst=0, inst_pc=0.
- FSM states BOOT, RUN, FLUSH:
  - BOOT: one cycle with no request, then RUN.
  - RUN: imem_req=1 when count+outstanding < DEPTH. On grant: fetch_pc += PC_INC and outstanding++. Each rvalid writes {imem_rdata, pc} into the FIFO and decrements outstanding.
  - FLUSH: entered on redirect while outstanding-after-this-cycle > 0. discard is loaded with that count; imem_req=0; each rvalid is dropped and decrements discard. When discard reaches 0, return to RUN (a request may be issued that same cycle).
- Latency and FIFO tagging:
  - Minimum request-to-inst_valid latency is response latency + 1 cycle; responses are registered into the FIFO, with no combinational path from imem_rdata to inst.
  - Each FIFO entry's pc comes from a parallel DEPTH-entry pc queue written at grant time.
- Redirect (any state, has priority over every other event in that cycle):
  - FIFO cleared; fetch_pc=redirect_addr; inst_valid=0 on the next cycle.
  - A same-cycle grant is counted as outstanding, so it is discarded.
  - A same-cycle rvalid is discarded.
  - A same-cycle dequeue has no effect.
  - Redirect while in FLUSH reloads discard with the current outstanding count.
  - If the resulting outstanding count is 0, go to RUN; the first request at redirect_addr is issued the cycle after redirect.
- FIFO:
  - Simultaneous write and read when full or empty is legal; count is unchanged.
  - A write when count=DEPTH cannot occur by construction; it is an assertion failure.
  - Pointers wrap modulo DEPTH.
- Handshake rules:
  - imem_req/imem_addr are held stable until granted, unless a redirect occurs.
  - inst/inst_pc are held stable while inst_valid & !inst_ready.
- Arithmetic: fetch_pc wraps modulo 2^WIDTH (max address + PC_INC wraps to low addresses, no error).

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined:
  - Adds outputs stat_fetched (32b, count of instructions dequeued by decode) and stat_flushed (32b, count of FIFO entries plus in-flight responses discarded by redirects).
  - Both counters reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_gnt=1, 1-cycle response latency, inst_ready=1 -> addresses 0,1,2,3… issued back-to-back; inst_pc sequence 0,1,2… with one instruction per cycle in steady state.
- inst_ready=0 with DEPTH=4 -> exactly 4 grants occur, then imem_req=0; FIFO holds pc 0..3. Raising inst_ready -> fetching resumes at addr 4, with no loss or duplication.
- imem_gnt low for 5 cycles on addr 2 -> imem_req=1 and imem_addr=2 held stable for all 5 cycles; no inst_valid for pc 2 before its grant.
- 3-cycle latency, redirect to 0x100 with 2 requests in flight and 1 FIFO entry -> inst_valid=0 next cycle; state FLUSH; both responses dropped; first issued address is 0x100; first inst_pc=0x100. With FETCH_STATS_EN: stat_flushed=3.
- Redirect in the same cycle as dequeue, grant and rvalid -> the dequeued entry is not counted by stat_fetched; the granted and returned words never appear on inst.
- Async reset asserted mid-FLUSH with outstanding=2 -> all outputs zero immediately; after release, BOOT then fetch from RESET_PC; late stale rvalids from the memory model are disabled in the bench.
